// File: rtl/moving_average_n_if.sv
// Sample-stream interface for the moving-average filter: strobe, length select,
// input sample, and the averaged result with its valid/primed flags.
interface moving_average_n_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2_W     = 3
);
    logic                         ce;
    logic        [LOG2_W-1:0]     log2_len;
    logic signed [DATA_WIDTH-1:0] din;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         dout_valid;
    logic                         primed;

    // Upstream source: drives samples, reads the average.
    modport master (
        output ce,
        output log2_len,
        output din,
        input  dout,
        input  dout_valid,
        input  primed
    );

    // Filter side.
    modport slave (
        input  ce,
        input  log2_len,
        input  din,
        output dout,
        output dout_valid,
        output primed
    );
endinterface

// File: rtl/moving_average_n.sv
// Boxcar filter of run-time length 2^k over a signed sample stream. Keeps a
// recursive running sum over a circular buffer; output is rounded half-up and
// divided by 2^k. Missing samples before the window fills count as zero.
module moving_average_n #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned LOG2_LEN_MAX = 5,
    parameter int unsigned LOG2_W       = 3
) (
    input logic               clk,
    input logic               rst,
    moving_average_n_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << LOG2_LEN_MAX;
    localparam int unsigned ACC_W  = DATA_WIDTH + LOG2_LEN_MAX;
    localparam int unsigned PTR_W  = LOG2_LEN_MAX;
    localparam int unsigned FILL_W = LOG2_LEN_MAX + 1;
    localparam logic [LOG2_W-1:0] LEN_MAX = LOG2_W'(LOG2_LEN_MAX);

    logic        [LOG2_W-1:0]     len_q, len_d, k_req;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic        [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_idx;
    logic        [FILL_W-1:0]     fill_q, fill_d, len_n;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                         dout_valid_q, dout_valid_d;
    logic                         primed_q, primed_d;
    logic signed [DATA_WIDTH-1:0] buf_mem [DEPTH];

    logic                         len_change;
    logic                         accept;
    logic                         full;
    logic signed [DATA_WIDTH-1:0] old_sample;
    logic signed [ACC_W-1:0]      old_ext, din_ext, sum_next, rnd, sum_rnd;

    // Window geometry, sample retiring and rounded average for this cycle.
    always_comb begin
        k_req      = (bus.log2_len > LEN_MAX) ? LEN_MAX : bus.log2_len;
        len_change = (k_req != len_q);
        accept     = bus.ce && !len_change;
        len_n      = FILL_W'(1) << len_q;
        full       = (fill_q == len_n);
        // For k = LOG2_LEN_MAX the offset truncates to 0: the slot about to be
        // overwritten is exactly the sample leaving the window.
        rd_idx     = wr_ptr_q - len_n[PTR_W-1:0];
        old_sample = buf_mem[rd_idx];
        old_ext    = full ? {{LOG2_LEN_MAX{old_sample[DATA_WIDTH-1]}}, old_sample} : '0;
        din_ext    = {{LOG2_LEN_MAX{bus.din[DATA_WIDTH-1]}}, bus.din};
        sum_next   = acc_q + din_ext - old_ext;
        rnd        = (len_q == '0) ? '0 : ACC_W'(1) << (len_q - LOG2_W'(1));
        // Headroom: |sum| <= 2^k * 2^(DATA_WIDTH-1), so adding R cannot overflow.
        sum_rnd    = sum_next + rnd;
    end

    // Next-state: length change flushes the window, an accepted sample advances it.
    always_comb begin
        len_d        = len_q;
        acc_d        = acc_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        primed_d     = primed_q;
        if (len_change) begin
            len_d    = k_req;
            acc_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (bus.ce) begin
            acc_d        = sum_next;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            fill_d       = full ? fill_q : fill_q + FILL_W'(1);
            dout_d       = DATA_WIDTH'(sum_rnd >>> len_q);
            dout_valid_d = 1'b1;
            primed_d     = (fill_d == len_n);
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= LEN_MAX;
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            len_q        <= len_d;
            acc_q        <= acc_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            primed_q     <= primed_d;
        end
    end

    // Sample history; contents are only ever read once fill marks them valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.primed     = primed_q;

endmodule

// File: tb/tb_moving_average_n.sv
// Directed bench for moving_average_n: reset, step, rounding, full scale,
// length change, sparse strobes with clamp and k=0, and mid-run reset.
module tb_moving_average_n;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    moving_average_n_if #(.DATA_WIDTH(16), .LOG2_W(3)) bus ();

    moving_average_n #(
        .DATA_WIDTH  (16),
        .LOG2_LEN_MAX(5),
        .LOG2_W      (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic [2:0] l, input logic signed [15:0] d);
        bus.ce       = c;
        bus.log2_len = l;
        bus.din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst          = 1'b0;
        bus.ce       = 1'b0;
        bus.log2_len = 3'd5;
        bus.din      = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got dout=%0d valid=%b primed=%b, expected 0/0/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 3'd5, 16'sd0);
            checks++;
            if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got dout=%0d valid=%b primed=%b, expected 0/0/0",
                         i, bus.dout, bus.dout_valid, bus.primed);
            end
        end
    endtask

    task automatic test_step;
        logic signed [15:0] exp_d [6];
        exp_d = '{16'sd25, 16'sd50, 16'sd75, 16'sd100, 16'sd100, 16'sd100};
        cyc(1'b0, 3'd2, 16'sd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 3'd2, 16'sd100);
            checks++;
            if (bus.dout !== exp_d[i] || bus.dout_valid !== 1'b1 || bus.primed !== (i >= 3)) begin
                errors++;
                $display("FAIL step[%0d]: got dout=%0d valid=%b primed=%b, expected %0d/1/%b",
                         i, bus.dout, bus.dout_valid, bus.primed, exp_d[i], (i >= 3));
            end
        end
        cyc(1'b0, 3'd2, 16'sd7);
        checks++;
        if (bus.dout !== 16'sd100 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b1) begin
            errors++;
            $display("FAIL step_hold: got dout=%0d valid=%b primed=%b, expected 100/0/1",
                     bus.dout, bus.dout_valid, bus.primed);
        end
    endtask

    task automatic test_rounding;
        logic signed [15:0] vin   [5];
        logic signed [15:0] exp_d [5];
        vin   = '{16'sd1, 16'sd2, -16'sd1, -16'sd2, -16'sd3};
        exp_d = '{16'sd1, 16'sd2, 16'sd1, -16'sd1, -16'sd2};
        cyc(1'b0, 3'd1, 16'sd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 3'd1, vin[i]);
            checks++;
            if (bus.dout !== exp_d[i] || bus.dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL round[%0d]: got dout=%0d valid=%b, expected %0d/1",
                         i, bus.dout, bus.dout_valid, exp_d[i]);
            end
        end
    endtask

    task automatic test_full_scale;
        logic signed [15:0] exp_d;
        cyc(1'b0, 3'd5, 16'sd0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 3'd5, 16'sh8000);
            if (i == 0 || i == 31 || i == 39) begin
                exp_d = (i == 0) ? -16'sd1024 : 16'sh8000;
                checks++;
                if (bus.dout !== exp_d || bus.primed !== (i >= 31)) begin
                    errors++;
                    $display("FAIL fs_neg[%0d]: got dout=%0d primed=%b, expected %0d/%b",
                             i, bus.dout, bus.primed, exp_d, (i >= 31));
                end
            end
            if (i == 30) begin
                checks++;
                if (bus.primed !== 1'b0) begin
                    errors++;
                    $display("FAIL fs_primed_early: got primed=%b, expected 0", bus.primed);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 3'd5, 16'sh7fff);
            if (i == 15 || i == 31 || i == 39) begin
                exp_d = (i == 15) ? 16'sd0 : 16'sh7fff;
                checks++;
                if (bus.dout !== exp_d || bus.dout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fs_pos[%0d]: got dout=%0d valid=%b, expected %0d/1",
                             i, bus.dout, bus.dout_valid, exp_d);
                end
            end
        end
    endtask

    task automatic test_length_change;
        cyc(1'b0, 3'd3, 16'sd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'd3, 16'sd80);
            if (i >= 6) begin
                checks++;
                if (bus.primed !== (i == 7) || (i == 7 && bus.dout !== 16'sd80)) begin
                    errors++;
                    $display("FAIL lc_fill[%0d]: got dout=%0d primed=%b, expected 80/%b",
                             i, bus.dout, bus.primed, (i == 7));
                end
            end
        end
        cyc(1'b1, 3'd1, 16'sd80);
        checks++;
        if (bus.dout !== 16'sd80 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL lc_drop: got dout=%0d valid=%b primed=%b, expected 80/0/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
        cyc(1'b1, 3'd1, 16'sd80);
        checks++;
        if (bus.dout !== 16'sd40 || bus.dout_valid !== 1'b1 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL lc_first: got dout=%0d valid=%b primed=%b, expected 40/1/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
        cyc(1'b1, 3'd1, 16'sd80);
        checks++;
        if (bus.dout !== 16'sd80 || bus.dout_valid !== 1'b1 || bus.primed !== 1'b1) begin
            errors++;
            $display("FAIL lc_second: got dout=%0d valid=%b primed=%b, expected 80/1/1",
                     bus.dout, bus.dout_valid, bus.primed);
        end
    endtask

    task automatic test_sparse;
        logic signed [15:0] exp_d [3];
        logic signed [15:0] vin   [3];
        exp_d = '{16'sd10, 16'sd20, 16'sd30};
        cyc(1'b0, 3'd7, 16'sd0);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 3'd7, 16'sd320);
            checks++;
            if (bus.dout !== exp_d[s] || bus.dout_valid !== 1'b1 || bus.primed !== 1'b0) begin
                errors++;
                $display("FAIL clamp[%0d]: got dout=%0d valid=%b primed=%b, expected %0d/1/0",
                         s, bus.dout, bus.dout_valid, bus.primed, exp_d[s]);
            end
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 3'd7, 16'sd999);
                checks++;
                if (bus.dout !== exp_d[s] || bus.dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL clamp_hold[%0d.%0d]: got dout=%0d valid=%b, expected %0d/0",
                             s, g, bus.dout, bus.dout_valid, exp_d[s]);
                end
            end
        end
        vin = '{16'sd7, -16'sd5, 16'sd1234};
        cyc(1'b0, 3'd0, 16'sd0);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 3'd0, vin[s]);
            checks++;
            if (bus.dout !== vin[s] || bus.dout_valid !== 1'b1 || bus.primed !== 1'b1) begin
                errors++;
                $display("FAIL k0[%0d]: got dout=%0d valid=%b primed=%b, expected %0d/1/1",
                         s, bus.dout, bus.dout_valid, bus.primed, vin[s]);
            end
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 3'd0, 16'sd77);
                checks++;
                if (bus.dout !== vin[s] || bus.dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL k0_hold[%0d.%0d]: got dout=%0d valid=%b, expected %0d/0",
                             s, g, bus.dout, bus.dout_valid, vin[s]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun;
        cyc(1'b1, 3'd0, 16'sd55);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got dout=%0d valid=%b primed=%b, expected 0/0/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
        bus.ce = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 3'd5, 16'sd0);
        checks++;
        if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got dout=%0d valid=%b primed=%b, expected 0/0/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
        cyc(1'b1, 3'd5, 16'sd320);
        checks++;
        if (bus.dout !== 16'sd10 || bus.dout_valid !== 1'b1 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_first: got dout=%0d valid=%b primed=%b, expected 10/1/0",
                     bus.dout, bus.dout_valid, bus.primed);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_step();
        test_rounding();
        test_full_scale();
        test_length_change();
        test_sparse();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
